// File: rtl/ans_pkg.sv
// Shared constants and FSM state encoding for the ANS encoder controller.
package ans_pkg;

    // Default widths, matching the attached ans_encoder instance.
    localparam int ANS_SYM_W       = 4;
    localparam int ANS_CNT_W       = 4;
    localparam int ANS_FLUSH_WORDS = 4;

    // Encoder state register width: the flush drains it one word at a time.
    localparam int ANS_STATE_W = ANS_FLUSH_WORDS * ANS_SYM_W;

    // Cumulative/total width: 2^SYM_W entries of CNT_W bits cannot overflow it.
    localparam int ANS_CUM_W = ANS_SYM_W + ANS_CNT_W;

    // Controller FSM state encoding.
    localparam int         ST_BITS  = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_RST   = 3'd2;
    localparam logic [2:0] ST_INIT  = 3'd3;
    localparam logic [2:0] ST_ENC   = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ans_freq_table.sv
// Frequency table: programmable per-symbol counts, a one-entry-per-cycle scan
// that builds the cumulative table and the total, and a combinational lookup.
module ans_freq_table
    import ans_pkg::*;
#(
    parameter int SYM_W = ANS_SYM_W,
    parameter int CNT_W = ANS_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [SYM_W-1:0]       wr_sym,
    input  logic [CNT_W-1:0]       wr_cnt,
    input  logic                   scan_en,
    output logic                   scan_last,
    output logic [SYM_W+CNT_W-1:0] scan_sum,
    input  logic [SYM_W-1:0]       look_sym,
    output logic [CNT_W-1:0]       look_cnt,
    output logic [SYM_W+CNT_W-1:0] look_cum,
    output logic [SYM_W+CNT_W-1:0] total
);

    localparam int CUM_W = SYM_W + CNT_W;
    localparam int DEPTH = 1 << SYM_W;

    logic [CNT_W-1:0] cnt_mem [DEPTH];
    logic [CUM_W-1:0] cum_mem [DEPTH];
    logic [SYM_W-1:0] idx;
    logic [CUM_W-1:0] acc;

    // The walker finishes on the all-ones index; the running sum includes it.
    assign scan_last = scan_en && (&idx);
    assign scan_sum  = acc + CUM_W'(cnt_mem[idx]);

    // Count RAM, written by the host while the controller is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these arrays are reset on purpose because an all-zero table is
        // part of the observable reset state; plain storage RAMs normally are not.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= '0;
        end else if (wr_en) begin
            cnt_mem[wr_sym] <= wr_cnt;
        end
    end

    // Scan walker: cum[i] gets the sum of all counts below i, total gets all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cum_mem[i] <= '0;
            idx   <= '0;
            acc   <= '0;
            total <= '0;
        end else if (scan_en) begin
            cum_mem[idx] <= acc;
            idx          <= idx + SYM_W'(1);
            if (&idx) begin
                total <= scan_sum;
                acc   <= '0;
            end else begin
                acc <= scan_sum;
            end
        end
    end

    assign look_cnt = cnt_mem[look_sym];
    assign look_cum = cum_mem[look_sym];

endmodule

// File: rtl/ans_enc_ctrl.sv
// Stream controller for one ans_encoder: builds the cumulative table, resets
// and initialises the encoder, feeds symbols, drives the flush and frames the
// output words. Optional statistics counters are enabled by ANS_CTRL_STATS_EN.
module ans_enc_ctrl
    import ans_pkg::*;
#(
    parameter int SYM_W       = ANS_SYM_W,
    parameter int CNT_W       = ANS_CNT_W,
    parameter int FLUSH_WORDS = ANS_FLUSH_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr,
    input  logic [SYM_W-1:0]       cfg_sym,
    input  logic [CNT_W-1:0]       cfg_cnt,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [SYM_W-1:0]       sym_in,
    input  logic                   sym_vld,
    input  logic                   sym_last,
    output logic                   sym_rdy,
    output logic                   enc_rst_n,
    output logic                   enc_ena,
    output logic [CNT_W-1:0]       enc_s_count,
    output logic [SYM_W+CNT_W-1:0] enc_s_cum,
    output logic [SYM_W+CNT_W-1:0] enc_total,
    output logic                   enc_in_vld,
    input  logic                   enc_in_rdy,
    input  logic [SYM_W-1:0]       enc_out,
    input  logic                   enc_out_vld,
    output logic                   enc_out_rdy,
    output logic [SYM_W-1:0]       out_data,
    output logic                   out_vld,
    output logic                   out_last,
    input  logic                   out_rdy,
    output logic [15:0]            stat_syms,
    output logic [15:0]            stat_words
);

    localparam int CUM_W = SYM_W + CNT_W;
    localparam int FC_W  = $clog2(FLUSH_WORDS + 1);

    logic [ST_BITS-1:0] state, state_nxt;
    logic               hold_vld, hold_last, chk;
    logic [SYM_W-1:0]   hold_sym;
    logic [FC_W-1:0]    flush_cnt;
    logic               scan_last;
    logic [CUM_W-1:0]   scan_sum;
    logic               in_enc, out_accept, retire, drop, flush_end;

    ans_freq_table #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cfg_wr && (state == ST_IDLE)),
        .wr_sym    (cfg_sym),
        .wr_cnt    (cfg_cnt),
        .scan_en   (state == ST_SCAN),
        .scan_last (scan_last),
        .scan_sum  (scan_sum),
        .look_sym  (hold_sym),
        .look_cnt  (enc_s_count),
        .look_cum  (enc_s_cum),
        .total     (enc_total)
    );

    assign in_enc    = (state == ST_ENC);
    assign busy      = (state != ST_IDLE);
    assign enc_rst_n = (state != ST_RST);
    assign enc_ena   = (state == ST_INIT) || in_enc;
    assign sym_rdy   = in_enc && !hold_vld;

    // A zero-count symbol is never presented: the encoder would divide by it.
    assign drop       = in_enc && hold_vld && !chk && (enc_s_count == '0);
    assign enc_in_vld = in_enc && hold_vld && !chk && (enc_s_count != '0);

    // The cycle after a handshake, a word from the encoder means it only
    // renormalised and the same symbol must be presented again.
    assign retire = in_enc && chk && !enc_out_vld;

    // Output path is a pass-through; ready is gated so the encoder never sees
    // ready while it has nothing to send (its flush step relies on that).
    assign out_data    = enc_out;
    assign out_vld     = enc_out_vld;
    assign enc_out_rdy = out_rdy & enc_out_vld;
    assign out_accept  = enc_out_vld & out_rdy;
    assign out_last    = (state == ST_FLUSH) && enc_out_vld &&
                         (flush_cnt == FC_W'(FLUSH_WORDS - 1));
    assign flush_end   = out_last && out_rdy;

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SCAN;
            ST_SCAN:  if (scan_last) state_nxt = (scan_sum == '0) ? ST_IDLE : ST_RST;
            ST_RST:   state_nxt = ST_INIT;
            ST_INIT:  state_nxt = ST_ENC;
            // A dropped final symbol still ends the stream so it cannot stall.
            ST_ENC:   if ((retire || drop) && hold_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register, symbol hold register, handshake check and flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // block samples the pre-edge values regardless of evaluation order.
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_vld  <= 1'b0;
            hold_last <= 1'b0;
            hold_sym  <= '0;
            chk       <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (sym_vld && sym_rdy) begin
                hold_vld  <= 1'b1;
                hold_sym  <= sym_in;
                hold_last <= sym_last;
            end else if (retire || drop) begin
                hold_vld <= 1'b0;
            end
            chk <= enc_in_vld && enc_in_rdy;
            if (state != ST_FLUSH) flush_cnt <= '0;
            else if (out_accept)   flush_cnt <= flush_cnt + FC_W'(1);
        end
    end

    // Completion pulse and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= flush_end;
            if ((state == ST_IDLE) && start)         err <= 1'b0;
            else if ((scan_last && scan_sum == '0) || drop) err <= 1'b1;
        end
    end

`ifdef ANS_CTRL_STATS_EN
    logic [15:0] syms_q, words_q;

    // Saturating counts of retired symbols and accepted output words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syms_q  <= '0;
            words_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            syms_q  <= '0;
            words_q <= '0;
        end else begin
            if (retire)     syms_q  <= sat_inc16(syms_q);
            if (out_accept) words_q <= sat_inc16(words_q);
        end
    end

    assign stat_syms  = syms_q;
    assign stat_words = words_q;
`else
    assign stat_syms  = '0;
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_ans_enc_ctrl.sv
// Testbench for ans_enc_ctrl with a behavioural rANS encoder model attached.
module tb_ans_enc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_wr, start, sym_vld, sym_last, out_rdy;
    logic [3:0] cfg_sym, cfg_cnt, sym_in;
    logic       busy, done, err, sym_rdy;
    logic       enc_rst_n, enc_ena, enc_in_vld, enc_in_rdy, enc_out_vld, enc_out_rdy;
    logic [3:0] enc_s_count, enc_out, out_data;
    logic [7:0] enc_s_cum, enc_total;
    logic       out_vld, out_last;
    logic [15:0] stat_syms, stat_words;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;
    exp_t sb[$];

    logic mon_en    = 1'b1;
    logic toggle_en = 1'b0;
    int   done_cnt, hs_cnt, rst_low_cnt, viol_cnt;

    always #5 clk = ~clk;

    ans_enc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_sym(cfg_sym), .cfg_cnt(cfg_cnt),
        .start(start), .busy(busy), .done(done), .err(err),
        .sym_in(sym_in), .sym_vld(sym_vld), .sym_last(sym_last), .sym_rdy(sym_rdy),
        .enc_rst_n(enc_rst_n), .enc_ena(enc_ena), .enc_s_count(enc_s_count),
        .enc_s_cum(enc_s_cum), .enc_total(enc_total), .enc_in_vld(enc_in_vld),
        .enc_in_rdy(enc_in_rdy), .enc_out(enc_out), .enc_out_vld(enc_out_vld),
        .enc_out_rdy(enc_out_rdy), .out_data(out_data), .out_vld(out_vld),
        .out_last(out_last), .out_rdy(out_rdy), .stat_syms(stat_syms), .stat_words(stat_words)
    );

    // rANS encoder model: renormalises when state >= count<<4, flushes four
    // low-first words only while idle-disabled with nothing pending.
    logic [15:0] m_state;
    logic [3:0]  m_out;
    logic        m_out_vld, m_init_pend, m_started;
    logic [2:0]  m_fcnt;

    assign enc_in_rdy  = !m_out_vld;
    assign enc_out     = m_out;
    assign enc_out_vld = m_out_vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= '0; m_out <= '0; m_out_vld <= 1'b0;
            m_init_pend <= 1'b0; m_started <= 1'b0; m_fcnt <= '0;
        end else if (!enc_rst_n) begin
            m_state <= '0; m_out_vld <= 1'b0;
            m_init_pend <= 1'b1; m_started <= 1'b0; m_fcnt <= '0;
        end else begin
            if (m_out_vld && enc_out_rdy) m_out_vld <= 1'b0;
            if (enc_ena) begin
                if (m_init_pend) begin
                    if (!enc_in_vld) begin
                        m_state <= 16'(enc_total) + 16'd1;
                        m_init_pend <= 1'b0;
                        m_started <= 1'b1;
                    end
                end else if (enc_in_vld && !m_out_vld) begin
                    if (m_state >= (16'(enc_s_count) << 4)) begin
                        m_out <= m_state[3:0]; m_out_vld <= 1'b1; m_state <= m_state >> 4;
                    end else begin
                        m_state <= (m_state / 16'(enc_s_count)) * 16'(enc_total)
                                   + 16'(enc_s_cum) + (m_state % 16'(enc_s_count));
                    end
                end
            end else if (m_started && m_fcnt < 3'd4 && !m_out_vld && !enc_out_rdy) begin
                m_out <= m_state[3:0]; m_state <= m_state >> 4;
                m_out_vld <= 1'b1; m_fcnt <= m_fcnt + 3'd1;
            end
        end
    end

    // Output monitor and event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (enc_out_rdy && !enc_out_vld) viol_cnt++;
            if (done) done_cnt++;
            if (!enc_rst_n) rst_low_cnt++;
            if (enc_in_vld && enc_in_rdy) hs_cnt++;
            if (mon_en && out_vld && out_rdy) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL out_word: unexpected word %h last=%b", out_data, out_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        fails++;
                        $display("FAIL out_word: got %h last=%b, want %h last=%b",
                                 out_data, out_last, e.data, e.last);
                    end
                end
            end
        end
    end

    // Downstream back-pressure generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (toggle_en) out_rdy = ~out_rdy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [3:0] d, input logic l);
        exp_t e;
        e.data = d; e.last = l;
        sb.push_back(e);
    endtask

    task automatic clear_counts();
        done_cnt = 0; hs_cnt = 0; rst_low_cnt = 0; viol_cnt = 0;
    endtask

    task automatic cfg_write(input logic [3:0] s, input logic [3:0] c);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_sym = s; cfg_cnt = c;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic start_stream();
        int n;
        clear_counts();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!sym_rdy && n < 100);
        tests++;
        if (!sym_rdy || !busy || err !== 1'b0) begin
            fails++;
            $display("FAIL stream_start: sym_rdy=%b busy=%b err=%b, want 1 1 0", sym_rdy, busy, err);
        end
    endtask

    // Feed one symbol; optionally confirm the table values presented for it.
    task automatic send_sym(input logic [3:0] s, input logic l, input logic present,
                            input logic [3:0] ecnt, input logic [7:0] ecum);
        int n;
        @(posedge clk); #1;
        sym_in = s; sym_vld = 1'b1; sym_last = l;
        n = 0;
        do begin @(negedge clk); n++; end while (!sym_rdy && n < 200);
        if (!sym_rdy) begin
            tests++; fails++;
            $display("FAIL sym_accept: sym %h not accepted", s);
        end
        @(posedge clk); #1;
        sym_vld = 1'b0; sym_last = 1'b0;
        if (present) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!enc_in_vld && n < 50);
            tests++;
            if (!enc_in_vld || enc_s_count !== ecnt || enc_s_cum !== ecum) begin
                fails++;
                $display("FAIL present_%h: vld=%b cnt=%h cum=%h, want 1 %h %h",
                         s, enc_in_vld, enc_s_count, enc_s_cum, ecnt, ecum);
            end
        end
    endtask

    task automatic wait_done(input int exp_hs);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 500);
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != 1 || sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stream_end: done_cnt=%0d left=%0d busy=%b, want 1 0 0",
                     done_cnt, sb.size(), busy);
        end
        tests++;
        if (hs_cnt != exp_hs) begin
            fails++;
            $display("FAIL handshakes: got %0d want %0d", hs_cnt, exp_hs);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({busy, done, err, sym_rdy, enc_rst_n, enc_ena, enc_in_vld, out_last} !== 8'b0000_1000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00001000",
                     {busy, done, err, sym_rdy, enc_rst_n, enc_ena, enc_in_vld, out_last});
        end
        tests++;
        if (enc_total !== 8'd0 || stat_syms !== 16'd0 || stat_words !== 16'd0) begin
            fails++;
            $display("FAIL reset_regs: total=%h syms=%h words=%h, want 0", enc_total, stat_syms, stat_words);
        end
    endtask

    task automatic test_scan();
        int n;
        cfg_write(4'd0, 4'd3);
        cfg_write(4'd1, 4'd1);
        clear_counts();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!enc_rst_n) break;
            n++;
        end
        tests++;
        if (n != 16 || enc_ena !== 1'b0) begin
            fails++;
            $display("FAIL scan_len: got %0d cycles ena=%b, want 16 0", n, enc_ena);
        end
        @(negedge clk);
        tests++;
        if (enc_rst_n !== 1'b1 || enc_ena !== 1'b1 || enc_in_vld !== 1'b0 || enc_total !== 8'd4) begin
            fails++;
            $display("FAIL init_cycle: rst_n=%b ena=%b in_vld=%b total=%h, want 1 1 0 04",
                     enc_rst_n, enc_ena, enc_in_vld, enc_total);
        end
        @(negedge clk);
        tests++;
        if (rst_low_cnt != 1 || sym_rdy !== 1'b1 || enc_ena !== 1'b1) begin
            fails++;
            $display("FAIL enc_entry: rst_low=%0d sym_rdy=%b ena=%b, want 1 1 1", rst_low_cnt, sym_rdy, enc_ena);
        end
    endtask

    task automatic test_encode();
        push_exp(4'hB, 1'b0);
        push_exp(4'h7, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b1);
        send_sym(4'd0, 1'b0, 1'b1, 4'd3, 8'd0);
        send_sym(4'd1, 1'b0, 1'b1, 4'd1, 8'd3);
        send_sym(4'd1, 1'b1, 1'b1, 4'd1, 8'd3);
        wait_done(4);
        tests++;
`ifdef ANS_CTRL_STATS_EN
        if (stat_syms !== 16'd3 || stat_words !== 16'd5) begin
`else
        if (stat_syms !== 16'd0 || stat_words !== 16'd0) begin
`endif
            fails++;
            $display("FAIL stats: syms=%0d words=%0d", stat_syms, stat_words);
        end
    endtask

    task automatic test_backpressure();
        push_exp(4'hB, 1'b0);
        push_exp(4'h7, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b1);
        toggle_en = 1'b1;
        start_stream();
        // Configuration writes and start while streaming must be ignored.
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_sym = 4'd1; cfg_cnt = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        cfg_wr = 1'b0; start = 1'b0;
        send_sym(4'd0, 1'b0, 1'b1, 4'd3, 8'd0);
        send_sym(4'd1, 1'b0, 1'b1, 4'd1, 8'd3);
        send_sym(4'd1, 1'b1, 1'b1, 4'd1, 8'd3);
        wait_done(4);
        toggle_en = 1'b0;
        @(posedge clk); #1 out_rdy = 1'b1;
        tests++;
        if (viol_cnt != 0 || enc_total !== 8'd4) begin
            fails++;
            $display("FAIL backpressure: rdy_violations=%0d total=%h, want 0 04", viol_cnt, enc_total);
        end
    endtask

    task automatic test_zero_total();
        int n;
        cfg_write(4'd0, 4'd0);
        cfg_write(4'd1, 4'd0);
        clear_counts();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 100);
        repeat (2) @(negedge clk);
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || rst_low_cnt != 0 || done_cnt != 0) begin
            fails++;
            $display("FAIL zero_total: err=%b busy=%b rst_low=%0d done=%0d, want 1 0 0 0",
                     err, busy, rst_low_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_cnt();
        cfg_write(4'd0, 4'd3);
        cfg_write(4'd1, 4'd1);
        push_exp(4'hB, 1'b0);
        push_exp(4'h1, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b1);
        start_stream();
        send_sym(4'd0, 1'b0, 1'b1, 4'd3, 8'd0);
        send_sym(4'd5, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (2) @(negedge clk);
        tests++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_cnt_err: err=%b busy=%b, want 1 1", err, busy);
        end
        send_sym(4'd1, 1'b1, 1'b1, 4'd1, 8'd3);
        wait_done(2);
    endtask

    task automatic test_reset_flush();
        int n, acc;
        mon_en = 1'b0;
        start_stream();
        send_sym(4'd0, 1'b1, 1'b1, 4'd3, 8'd0);
        acc = 0; n = 0;
        while (acc < 2 && n < 200) begin
            @(negedge clk);
            if (out_vld && out_rdy) acc++;
            n++;
        end
        tests++;
        if (acc != 2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_flush: words=%0d busy=%b, want 2 1", acc, busy);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, err, sym_rdy, enc_rst_n, enc_ena, enc_in_vld, out_last, out_vld} !== 9'b0000_1000_0
            || enc_total !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset: flags=%b total=%h, want 000010000 00",
                     {busy, done, err, sym_rdy, enc_rst_n, enc_ena, enc_in_vld, out_last, out_vld}, enc_total);
        end
        @(negedge clk); rst_n = 1'b1;
        mon_en = 1'b1;
        cfg_write(4'd0, 4'd3);
        cfg_write(4'd1, 4'd1);
        push_exp(4'h7, 1'b0);
        push_exp(4'h1, 1'b0);
        push_exp(4'h0, 1'b0);
        push_exp(4'h0, 1'b1);
        start_stream();
        send_sym(4'd1, 1'b1, 1'b1, 4'd1, 8'd3);
        wait_done(1);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_wr = 1'b0; cfg_sym = '0; cfg_cnt = '0; start = 1'b0;
        sym_in = '0; sym_vld = 1'b0; sym_last = 1'b0; out_rdy = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_scan();
        test_encode();
        test_backpressure();
        test_zero_total();
        test_zero_cnt();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ans_enc_ctrl.md
Name: ans_enc_ctrl

Overview:
- Stream controller that sequences one ans_encoder instance.
- Holds a programmable per-symbol frequency table and builds the cumulative table from it.
- Per stream: resets and initialises the encoder, feeds it count/cumulative/total for each incoming symbol and retires symbols only when the encoder actually consumed them.
- Drives the end-of-stream flush, frames the output word stream for the downstream packer, and sits between the host/symbol source and the encoder.

Parameters:
- SYM_W, 4, symbol and output-word width; equals encoder SYM_WIDTH.
- CNT_W, 4, frequency-count width; equals encoder CNT_WIDTH.
- FLUSH_WORDS, 4, words emitted by the encoder flush; equals encoder fixed flush count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  write cfg_cnt into table[cfg_sym]; honoured only in IDLE
- cfg_sym  in  SYM_W  table index
- cfg_cnt  in  CNT_W  frequency count
- start  in  1  begin a stream; honoured only in IDLE
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on flush completion
- err  out  1  sticky; cleared by start
- sym_in  in  SYM_W  symbol
- sym_vld  in  1  symbol valid
- sym_last  in  1  final symbol of the stream, qualified by sym_vld
- sym_rdy  out  1  symbol accepted into the hold register
- enc_rst_n  out  1  encoder-local reset
- enc_ena  out  1  encoder ena
- enc_s_count  out  CNT_W  count of the held symbol
- enc_s_cum  out  SYM_W+CNT_W  cumulative of the held symbol
- enc_total  out  SYM_W+CNT_W  sum of all counts
- enc_in_vld  out  1  encoder in_vld
- enc_in_rdy  in  1  encoder in_rdy
- enc_out  in  SYM_W  encoder output word
- enc_out_vld  in  1  encoder out_vld
- enc_out_rdy  out  1  encoder out_rdy
- out_data  out  SYM_W  output word, equal to enc_out
- out_vld  out  1  output word valid
- out_last  out  1  final flush word
- out_rdy  in  1  downstream ready
- stat_syms  out  16  see Optional Feature
- stat_words  out  16  see Optional Feature

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; table and cumulatives cleared; hold register empty.
  - busy=0, done=0, err=0, sym_rdy=0, enc_rst_n=1, enc_ena=0, enc_in_vld=0, out_last=0.
  - Reset mid-stream drops the stream with no flush.
- FSM states and transitions:
  - IDLE: cfg_wr writes the table. start clears err and goes to SCAN.
  - SCAN: one entry per cycle over 2^SYM_W cycles; cum[i] = sum of cnt[0..i-1]; total accumulates at SYM_W+CNT_W width, no overflow possible. If total==0 at the end: set err and return to IDLE. Otherwise go to RST.
  - RST: enc_rst_n=0 for exactly one cycle. This clears the encoder's state and flush counter for every stream.
  - INIT: enc_ena=1 and enc_in_vld=0 for one cycle, so the encoder loads state=total+1. Then go to ENC.
  - ENC: enc_ena=1.
    - sym_rdy=1 only while the hold register is empty.
    - A held symbol with cnt==0 is dropped, err is set, and it is never presented; this prevents divide-by-zero.
    - Otherwise enc_in_vld=1 with the table values.
    - On handshake (enc_in_vld & enc_in_rdy), check the next cycle: enc_out_vld=1 means renormalisation and the symbol stays held; enc_out_vld=0 means the symbol is retired.
    - Retiring a symbol marked last, with enc_out_vld=0, goes to FLUSH.
  - FLUSH: enc_ena=0, enc_in_vld=0, sym_rdy=0. Count words accepted downstream. out_last=1 on word FLUSH_WORDS. On that word's acceptance, pulse done and go to IDLE.
- Output path, all states (combinational):
  - out_vld = enc_out_vld; out_data = enc_out.
  - enc_out_rdy = out_rdy & enc_out_vld.
  - The gating is mandatory: the encoder emits a flush word only while its out_vld=0 and out_rdy=0.
- Edge cases:
  - cfg_wr or start outside IDLE is ignored.
  - sym_vld in other states is not accepted.

Optional Feature:
- Macro ANS_CTRL_STATS_EN.
- Defined: stat_syms counts retired symbols; stat_words counts accepted output words. Both cleared on start, saturate at 0xFFFF.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Package ans_pkg: SYM_W/CNT_W/STATE_W constants (STATE_W = FLUSH_WORDS*SYM_W), cumulative-width constant, FSM state enum.
- Sub-module ans_freq_table: count RAM, SCAN walker, cumulative RAM, total register, combinational lookup by symbol.

Test Plan:
- cnt[0]=3, cnt[1]=1, all others 0; start -> SCAN lasts 16 cycles; enc_total=4, cum[0]=0, cum[1]=3; one RST cycle; one INIT cycle.
- Encode symbols 0,1,1 (last on third) with out_rdy=1 -> encoder states 5->6->27; word 0xB emitted with symbol 1 re-presented; state 1->7; flush words 7,0,0,0; out_last on the 4th; done pulses once.
- Same stream with out_rdy toggling 1/0 every cycle -> identical word sequence, no duplicates or loss, enc_out_rdy never high while enc_out_vld=0.
- All counts 0; start -> err=1, returns to IDLE, enc_rst_n never asserted.
- Symbol 5 with cnt 0 mid-stream -> err=1, symbol dropped, stream completes normally.
- Assert rst_n low during FLUSH after word 2, then run a new stream -> reset values seen, and the new stream's flush emits exactly 4 words.
